// File: rtl/div_pkg.sv
// Shared types for the sequential signed/unsigned divider: FSM states,
// the per-iteration step result and the most-negative-value helper.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef struct packed {
      logic q_bit;
   } step_res_t;

   localparam int unsigned DIV_MAX_W = 64;

   // Bit pattern 100..0 for a w-bit two's complement word (w <= DIV_MAX_W).
   function automatic logic [DIV_MAX_W-1:0] div_most_neg(input int unsigned w);
      return {{(DIV_MAX_W-1){1'b0}}, 1'b1} << (w - 1);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, compare
// the (N+1)-bit partial remainder with the divisor and subtract when it fits.
module div_step
   import div_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0] rem,
   input  logic         din,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] rem_next,
   output step_res_t    res
);

   logic [N:0] shifted;
   logic       ge;

   assign shifted = {rem, din};

   // The difference always fits in N bits because rem < divisor on entry.
   always_comb begin
      ge        = (shifted >= {1'b0, divisor});
      res       = '0;
      res.q_bit = ge;
      rem_next  = ge ? N'(shifted - {1'b0, divisor}) : shifted[N-1:0];
   end

endmodule

// File: rtl/divisor_secuencial_signed.sv
// Sequential restoring divider, signed or unsigned per request, with
// valid/ready handshakes. Optional build macro: DIV_EARLY_OUT_EN.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CALC  | one shift-subtract step per clock on magnitudes
// FIX   | apply quotient/remainder signs, register Q and R
// DONE  | result presented until out_ready
module divisor_secuencial_signed
   import div_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         signed_mode,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] Q,
   output logic [N-1:0] R,
   output logic         div_zero,
   output logic         overflow,
   output logic         busy
);

   localparam int CNT_W = $clog2(N + 1);
   localparam logic [N-1:0] MOST_NEG = N'(div_most_neg(N));
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

   state_t state, state_nxt;

   logic [N-1:0]     dvd, dvs, rem, quot;
   logic [CNT_W-1:0] cnt;
   logic             q_neg, r_neg;

   logic             a_neg, b_neg;
   logic [N-1:0]     a_mag, b_mag;
   logic             zero_case, ovf_case, direct_done;

   logic [N-1:0]     rem_next;
   step_res_t        step_res;

`ifdef DIV_EARLY_OUT_EN
   logic             big_div, unit_div;
`endif

   always_comb begin
      a_neg     = signed_mode & A[N-1];
      b_neg     = signed_mode & B[N-1];
      a_mag     = a_neg ? -A : A;
      b_mag     = b_neg ? -B : B;
      zero_case = (B == '0);
      ovf_case  = signed_mode && (A == MOST_NEG) && (B == '1);
`ifdef DIV_EARLY_OUT_EN
      big_div     = (b_mag > a_mag);
      unit_div    = (b_mag == N'(1));
      direct_done = zero_case | ovf_case | big_div | unit_div;
`else
      direct_done = zero_case | ovf_case;
`endif
   end

   div_step #(.N(N)) u_step (
      .rem      (rem),
      .din      (dvd[N-1]),
      .divisor  (dvs),
      .rem_next (rem_next),
      .res      (step_res)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = direct_done ? DONE : CALC;
         CALC: if (cnt == LAST_STEP) state_nxt = FIX;
         FIX:  state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      busy      = (state != IDLE);
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Q        <= '0;
         R        <= '0;
         div_zero <= 1'b0;
         overflow <= 1'b0;
         dvd      <= '0;
         dvs      <= '0;
         rem      <= '0;
         quot     <= '0;
         cnt      <= '0;
         q_neg    <= 1'b0;
         r_neg    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               div_zero <= 1'b0;
               overflow <= 1'b0;
               if (zero_case) begin
                  Q        <= '1;
                  R        <= A;
                  div_zero <= 1'b1;
               end else if (ovf_case) begin
                  Q        <= A;
                  R        <= '0;
                  overflow <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
               end else if (big_div) begin
                  Q <= '0;
                  R <= A;
               end else if (unit_div) begin
                  Q <= b_neg ? -A : A;
                  R <= '0;
`endif
               end else begin
                  dvd   <= a_mag;
                  dvs   <= b_mag;
                  rem   <= '0;
                  quot  <= '0;
                  cnt   <= '0;
                  q_neg <= a_neg ^ b_neg;
                  r_neg <= a_neg;
               end
            end
            CALC: begin
               rem  <= rem_next;
               quot <= {quot[N-2:0], step_res.q_bit};
               dvd  <= {dvd[N-2:0], 1'b0};
               cnt  <= cnt + 1'b1;
            end
            FIX: begin
               Q <= q_neg ? -quot : quot;
               R <= r_neg ? -rem : rem;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_divisor_secuencial_signed.sv
// Self-checking bench for divisor_secuencial_signed (N=8): directed vector
// table, randomized requests against an integer-arithmetic model, stall and reset sequences.
module tb_divisor_secuencial_signed;

   localparam int W = 8;
   localparam int LAT_FULL = W + 2;
`ifdef DIV_EARLY_OUT_EN
   localparam int LAT_E = 1;
`else
   localparam int LAT_E = W + 2;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         signed_mode = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] Q, R;
   logic         div_zero, overflow, busy;

   int n_checks = 0;
   int n_err = 0;

   divisor_secuencial_signed #(.N(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .signed_mode (signed_mode),
      .A           (A),
      .B           (B),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .Q           (Q),
      .R           (R),
      .div_zero    (div_zero),
      .overflow    (overflow),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sm;
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
      logic       ov;
      int         lat;
   } vec_t;

   vec_t tv[12];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic int iabs(input int x);
      return (x < 0) ? -x : x;
   endfunction

   // Reference: plain integer division (truncates toward zero, remainder takes dividend sign).
   function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic sm,
                                 output logic [7:0] q, output logic [7:0] r,
                                 output logic dz, output logic ov, output int lat);
      int sa, sb;
      sa = sm ? int'($signed(a)) : int'(a);
      sb = sm ? int'($signed(b)) : int'(b);
      dz = 1'b0;
      ov = 1'b0;
      lat = LAT_FULL;
      if (sb == 0) begin
         q = 8'hFF; r = a; dz = 1'b1; lat = 1;
      end else if (sm && sa == -128 && sb == -1) begin
         q = a; r = 8'h00; ov = 1'b1; lat = 1;
      end else begin
         q = 8'(sa / sb);
         r = 8'(sa % sb);
`ifdef DIV_EARLY_OUT_EN
         if (iabs(sb) > iabs(sa) || iabs(sb) == 1) lat = 1;
`endif
      end
   endfunction

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sm,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dz, output logic ov, output int lat);
      @(negedge clk);
      A = a; B = b; signed_mode = sm; in_valid = 1'b1;
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      A = 8'($urandom); B = 8'($urandom); signed_mode = 1'($urandom);
      lat = 1;
      while (!out_valid && lat < 40) begin
         chk("in_ready_busy", 32'(in_ready), 32'd0);
         @(posedge clk);
         #1;
         lat++;
      end
      if (!out_valid) begin
         n_checks++;
         n_err++;
         $display("FAIL out_valid_timeout: got 0 expected 1 within 40 edges");
      end
      q = Q; r = R; dz = div_zero; ov = overflow;
   endtask

   task automatic retire();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("in_ready_after_retire", 32'(in_ready), 32'd1);
      chk("out_valid_after_retire", 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [7:0] gq, gr, eq, er, ra, rb;
      logic       gdz, gov, edz, eov, rsm;
      int         glat, elat, sel;

      tv[0]  = '{8'd100, 8'd7,  1'b0, 8'h0E, 8'h02, 1'b0, 1'b0, LAT_FULL};
      tv[1]  = '{8'h9C,  8'h07, 1'b1, 8'hF2, 8'hFE, 1'b0, 1'b0, LAT_FULL};
      tv[2]  = '{8'h64,  8'hF9, 1'b1, 8'hF2, 8'h02, 1'b0, 1'b0, LAT_FULL};
      tv[3]  = '{8'h55,  8'h00, 1'b0, 8'hFF, 8'h55, 1'b1, 1'b0, 1};
      tv[4]  = '{8'h55,  8'h00, 1'b1, 8'hFF, 8'h55, 1'b1, 1'b0, 1};
      tv[5]  = '{8'h80,  8'hFF, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0, LAT_E};
      tv[6]  = '{8'h80,  8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 1'b1, 1};
      tv[7]  = '{8'h80,  8'h02, 1'b1, 8'hC0, 8'h00, 1'b0, 1'b0, LAT_FULL};
      tv[8]  = '{8'd200, 8'd13, 1'b0, 8'd15,  8'd5,  1'b0, 1'b0, LAT_FULL};
      tv[9]  = '{8'd3,   8'd9,  1'b0, 8'h00, 8'h03, 1'b0, 1'b0, LAT_E};
      tv[10] = '{8'h07,  8'h01, 1'b1, 8'h07, 8'h00, 1'b0, 1'b0, LAT_E};
      tv[11] = '{8'hF9,  8'hFF, 1'b1, 8'h07, 8'h00, 1'b0, 1'b0, LAT_E};

      #2;
      chk("rst_Q", 32'(Q), 32'd0);
      chk("rst_R", 32'(R), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_flags", 32'({div_zero, overflow}), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      #20;
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         run_op(tv[i].a, tv[i].b, tv[i].sm, gq, gr, gdz, gov, glat);
         chk($sformatf("vec%0d_Q", i), 32'(gq), 32'(tv[i].q));
         chk($sformatf("vec%0d_R", i), 32'(gr), 32'(tv[i].r));
         chk($sformatf("vec%0d_div_zero", i), 32'(gdz), 32'(tv[i].dz));
         chk($sformatf("vec%0d_overflow", i), 32'(gov), 32'(tv[i].ov));
         chk($sformatf("vec%0d_latency", i), 32'(glat), 32'(tv[i].lat));
         retire();
      end

      for (int i = 0; i < 150; i++) begin
         sel = $urandom_range(0, 9);
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         rsm = 1'($urandom);
         if (sel == 0) rb = 8'h00;
         if (sel == 1) begin ra = 8'h80; rb = 8'hFF; end
         if (sel == 2) rb = 8'($urandom_range(1, 3));
         if (sel == 3) rb = 8'hFF;
         model(ra, rb, rsm, eq, er, edz, eov, elat);
         run_op(ra, rb, rsm, gq, gr, gdz, gov, glat);
         chk($sformatf("rnd%0d_Q a=%0h b=%0h s=%0d", i, ra, rb, rsm), 32'(gq), 32'(eq));
         chk($sformatf("rnd%0d_R a=%0h b=%0h s=%0d", i, ra, rb, rsm), 32'(gr), 32'(er));
         chk($sformatf("rnd%0d_flags", i), 32'({gdz, gov}), 32'({edz, eov}));
         chk($sformatf("rnd%0d_latency", i), 32'(glat), 32'(elat));
         retire();
      end

      // Stalled consumer: result must hold and new requests must be ignored.
      run_op(8'd100, 8'd7, 1'b0, gq, gr, gdz, gov, glat);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         in_valid = k[0];
         A = 8'h55; B = 8'h00; signed_mode = 1'b1;
         chk("stall_Q", 32'(Q), 32'h0E);
         chk("stall_R", 32'(R), 32'h02);
         chk("stall_flags", 32'({div_zero, overflow}), 32'd0);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
      end
      @(negedge clk);
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("release_in_ready", 32'(in_ready), 32'd1);
      chk("release_busy", 32'(busy), 32'd0);
      chk("release_out_valid", 32'(out_valid), 32'd0);
      in_valid = 1'b0;

      // Leave a non-zero result registered, then reset in the middle of a divide.
      run_op(8'h55, 8'h00, 1'b0, gq, gr, gdz, gov, glat);
      retire();
      @(negedge clk);
      A = 8'd200; B = 8'd13; signed_mode = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("midrst_Q", 32'(Q), 32'd0);
      chk("midrst_R", 32'(R), 32'd0);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      chk("postrst_idle_busy", 32'(busy), 32'd0);
      run_op(8'd200, 8'd13, 1'b0, gq, gr, gdz, gov, glat);
      chk("postrst_Q", 32'(gq), 32'd15);
      chk("postrst_R", 32'(gr), 32'd5);
      chk("postrst_latency", 32'(glat), 32'(LAT_FULL));
      retire();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
